nv_blkbox_sink_arb: RTL and testbench

NV_BLKBOX_SINK_ARB -- requirements
Module: nv_blkbox_sink_arb

---
 rtl/nv_blkbox_sink_arb.sv | 113 +++++++++++
 tb/tb_nv_blkbox_sink_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_blkbox_sink_arb.sv
// nv_blkbox_sink_arb
// Round-robin arbiter that merges four valid/ready requesters onto one
// registered sink port. It also keeps a saturating count of accepted beats
// for each requester.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | output register empty, sink_valid low
// BUSY  | output register holds a beat for the sink
module nv_blkbox_sink_arb #(
    parameter int DW = 32,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            sink_valid,
    output logic [DW-1:0]   sink_data,
    input  logic            sink_ready,
    input  logic [N-1:0]    cfg_en,
    input  logic            cnt_clr,
    output logic [N*CW-1:0] grant_cnt,
    output logic [1:0]      sink_src
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [N-1:0]    eligible;
    logic [1:0]      win;
    logic [1:0]      cand;
    logic            win_found;
    logic            can_load;
    logic            handshake;
    logic [CW-1:0]   cnt [N];

    assign eligible = req_valid & cfg_en;

    // Find the first eligible requester at or after rr_ptr, wrapping from 3 to 0.
    always_comb begin
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = rr_ptr + 2'(k);
            if (!win_found && eligible[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // The output register can take a new beat when it is empty, or when it is
    // being drained in this same cycle. Reset suppresses every grant.
    assign can_load  = (state == IDLE) || sink_ready;
    assign handshake = win_found && can_load && !nvdla_core_rst;

    // One-hot accept to the winning requester only.
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[win] = 1'b1;
        end
    end

    // Output-register FSM. sink_valid is a flop, so sink_ready has no
    // combinational path to the sink side.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state      <= IDLE;
            sink_valid <= 1'b0;
            sink_data  <= '0;
            sink_src   <= '0;
            rr_ptr     <= '0;
        end else if (handshake) begin
            state      <= BUSY;
            sink_valid <= 1'b1;
            sink_data  <= req_data[win*DW +: DW];
            sink_src   <= win;
            rr_ptr     <= win + 2'd1;
        end else if (state == BUSY && sink_ready) begin
            state      <= IDLE;
            sink_valid <= 1'b0;
        end
    end

    // Saturating per-requester grant counters. A clear wins over a same-cycle grant.
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < N; i++) begin
            if (nvdla_core_rst || cnt_clr) begin
                cnt[i] <= '0;
            end else if (req_ready[i] && (cnt[i] != {CW{1'b1}})) begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*CW +: CW] = cnt[i];
        end
    end

endmodule

// File: tb/tb_nv_blkbox_sink_arb.sv
// Testbench for nv_blkbox_sink_arb: fixed vector tables, hand-written corner
// sequences, and random traffic compared against a behavioural model.
module tb_nv_blkbox_sink_arb;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    req_valid;
    logic [127:0]  req_data;
    logic [3:0]    req_ready;
    logic          sink_valid;
    logic [31:0]   sink_data;
    logic          sink_ready;
    logic [3:0]    cfg_en;
    logic          cnt_clr;
    logic [63:0]   grant_cnt;
    logic [1:0]    sink_src;

    nv_blkbox_sink_arb #(.DW(32), .N(4), .CW(16)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .sink_valid     (sink_valid),
        .sink_data      (sink_data),
        .sink_ready     (sink_ready),
        .cfg_en         (cfg_en),
        .cnt_clr        (cnt_clr),
        .grant_cnt      (grant_cnt),
        .sink_src       (sink_src)
    );

    // Narrow-counter instance so that saturation is reached in a few cycles.
    logic          s_rst;
    logic [3:0]    s_valid;
    logic [127:0]  s_data;
    logic [3:0]    s_ready;
    logic          s_sv;
    logic [31:0]   s_sd;
    logic          s_sr;
    logic [3:0]    s_en;
    logic          s_clr;
    logic [15:0]   s_cnt;
    logic [1:0]    s_src;

    nv_blkbox_sink_arb #(.DW(32), .N(4), .CW(4)) u_sat (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (s_rst),
        .req_valid      (s_valid),
        .req_data       (s_data),
        .req_ready      (s_ready),
        .sink_valid     (s_sv),
        .sink_data      (s_sd),
        .sink_ready     (s_sr),
        .cfg_en         (s_en),
        .cnt_clr        (s_clr),
        .grant_cnt      (s_cnt),
        .sink_src       (s_src)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dat(input int i);
        return 32'hD000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic logic [127:0] dat_bus();
        return {dat(3), dat(2), dat(1), dat(0)};
    endfunction

    // Behavioural model: an output slot, a pointer and four counters.
    bit          m_busy;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_cnt [4];
    logic [3:0]  last_ready;

    function automatic int m_pick();
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (req_valid[i] && cfg_en[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check the combinational accept mid-cycle, advance the model
    // on the edge, then check registered outputs just after it.
    task automatic run_cycle();
        int          w;
        bit          hs;
        logic [3:0]  m_ready;
        logic [63:0] exp_cnt;
        @(negedge clk);
        w  = m_pick();
        hs = !rst && (w >= 0) && (!m_busy || sink_ready);
        m_ready = hs ? 4'(1 << w) : 4'b0;
        last_ready = req_ready;
        check("req_ready", req_ready, m_ready);
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_data = '0; m_src = 0; m_ptr = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            if (hs) begin
                m_data = req_data[w*32 +: 32];
                m_src  = w;
                m_busy = 1;
                m_ptr  = (w + 1) % 4;
            end else if (m_busy && sink_ready) begin
                m_busy = 0;
            end
            if (cnt_clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (hs && m_cnt[w] < 65535) begin
                m_cnt[w]++;
            end
        end
        #1;
        check("sink_valid", 64'(sink_valid), 64'(m_busy));
        if (m_busy) begin
            check("sink_data", 64'(sink_data), 64'(m_data));
            check("sink_src", 64'(sink_src), 64'(m_src));
        end
        exp_cnt = {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
        check("grant_cnt", grant_cnt, exp_cnt);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] en;
        logic       sr;
        logic [3:0] exp_ready;
        logic       exp_sv;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] e,
                                input logic sr, input logic [3:0] er, input logic esv,
                                input logic [1:0] es);
        vec_t x;
        x.rst = r; x.valid = v; x.en = e; x.sr = sr;
        x.exp_ready = er; x.exp_sv = esv; x.exp_src = es;
        return x;
    endfunction

    int pulses;

    initial begin
        m_busy = 0; m_data = '0; m_src = 0; m_ptr = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        rst = 1'b1; req_valid = '0; req_data = dat_bus(); sink_ready = 1'b1;
        cfg_en = 4'hF; cnt_clr = 1'b0;
        s_rst = 1'b1; s_valid = '0; s_data = dat_bus(); s_sr = 1'b1; s_en = 4'hF; s_clr = 1'b0;

        // Reset, full round-robin, drain, then the 4'b1010 enable mask.
        tbl.push_back(mk(1'b1, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0));
        for (int g = 0; g < 8; g++)
            tbl.push_back(mk(1'b0, 4'hF, 4'hF, 1'b1, 4'(1 << (g % 4)), 1'b1, 2'(g % 4)));
        tbl.push_back(mk(1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3));
        for (int g = 0; g < 4; g++)
            tbl.push_back(mk(1'b0, 4'hF, 4'b1010, 1'b1, (g % 2 == 0) ? 4'b0010 : 4'b1000,
                             1'b1, (g % 2 == 0) ? 2'd1 : 2'd3));
        tbl.push_back(mk(1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3));

        for (int t = 0; t < tbl.size(); t++) begin
            rst = tbl[t].rst; req_valid = tbl[t].valid; cfg_en = tbl[t].en;
            sink_ready = tbl[t].sr; cnt_clr = 1'b0;
            run_cycle();
            check("tbl_ready", 64'(last_ready), 64'(tbl[t].exp_ready));
            check("tbl_sink_valid", 64'(sink_valid), 64'(tbl[t].exp_sv));
            if (tbl[t].exp_sv) begin
                check("tbl_sink_src", 64'(sink_src), 64'(tbl[t].exp_src));
                check("tbl_sink_data", 64'(sink_data), 64'(dat(int'(tbl[t].exp_src))));
            end
            if (t == 9) check("rr_counts", grant_cnt, 64'h0002_0002_0002_0002);
        end
        check("mask_counts", grant_cnt, 64'h0004_0002_0004_0002);

        // Single requester held off by a stalled sink.
        cfg_en = 4'hF; req_valid = 4'b0100; sink_ready = 1'b0;
        req_data[95:64] = 32'hA5A5_A5A5;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            if (last_ready[2]) begin
                pulses++;
                req_valid = 4'b0000;
            end
            check("stall_data", 64'(sink_data), 64'h0000_0000_A5A5_A5A5);
            check("stall_valid", 64'(sink_valid), 64'd1);
        end
        sink_ready = 1'b1;
        run_cycle();
        check("stall_pulses", 64'(pulses), 64'd1);
        check("stall_idle", 64'(sink_valid), 64'd0);
        req_data = dat_bus();

        // Reset while a beat is stuck in the output register.
        req_valid = 4'b0010; sink_ready = 1'b0;
        run_cycle();
        check("busy_before_rst", 64'(sink_valid), 64'd1);
        req_valid = 4'b0000; rst = 1'b1;
        run_cycle();
        check("rst_ready", 64'(last_ready), 64'd0);
        check("rst_valid", 64'(sink_valid), 64'd0);
        check("rst_counts", grant_cnt, 64'd0);
        rst = 1'b0; req_valid = 4'b1110; sink_ready = 1'b1;
        run_cycle();
        check("post_rst_grant", 64'(last_ready), 64'b0010);
        check("post_rst_src", 64'(sink_src), 64'd1);
        req_valid = 4'b0000;
        run_cycle();

        // Counter saturation and clear-beats-increment on the narrow instance.
        run_cycle();
        s_rst = 1'b0; s_valid = 4'b0001;
        for (int c = 0; c < 14; c++) run_cycle();
        check("sat_pre", 64'(s_cnt), 64'h000E);
        for (int c = 0; c < 3; c++) run_cycle();
        check("sat_hold", 64'(s_cnt), 64'h000F);
        s_clr = 1'b1;
        run_cycle();
        check("clr_grant_ready", 64'(last_ready), 64'd0);
        check("clr_wins", 64'(s_cnt), 64'h0000);
        s_clr = 1'b0; s_valid = 4'b0000;
        run_cycle();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 39) == 0);
            cnt_clr    = ($urandom_range(0, 19) == 0);
            req_valid  = 4'($urandom);
            cfg_en     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            sink_ready = ($urandom_range(0, 3) != 0);
            req_data   = {$urandom, $urandom, $urandom, $urandom};
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
